// File: rtl/multdiv_if.sv
// Request/response bundle between the execute stage (master) and multdiv_seq (slave).
// Defining MULTDIV_REMAINDER_EN adds the data_remainder response field.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy, data_remainder
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy, data_remainder
    );
`else
    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
`endif
endinterface

// File: rtl/multdiv_seq.sv
// Multi-cycle signed multiply (radix-2 shift-add) / divide (restoring) on one shared adder.
// Optional MULTDIV_REMAINDER_EN exposes the signed division remainder on data_remainder.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     hi_q, hi_d;       // product upper half / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // |multiplicand| or |divisor|
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
`ifdef MULTDIV_REMAINDER_EN
    logic               rsign_q, rsign_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   rem_fix;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     div_shift;
    logic               alu_sub;
    logic [WIDTH+1:0]   alu_a, alu_b, alu_y;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH:0]     div_hi;
    logic [WIDTH-1:0]   div_lo;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot;
    logic               div_ovf;
    logic               last_iter;

    assign a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Shared adder: adds the multiplicand to the upper half, or trial-subtracts the divisor.
    always_comb begin
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        alu_sub   = (state_q == DIV);
        alu_a     = alu_sub ? {1'b0, div_shift} : {1'b0, hi_q};
        alu_b     = {2'b00, opnd_q};
        alu_y     = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    always_comb begin
        mul_sum  = lo_q[0] ? alu_y[WIDTH:0] : hi_q;
        mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
        prod_mag = {mul_sum, lo_q[WIDTH-1:1]};
        prod     = sign_q ? -prod_mag : prod_mag;
        mul_ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

        div_hi   = alu_y[WIDTH+1] ? div_shift : alu_y[WIDTH:0];
        div_lo   = {lo_q[WIDTH-2:0], ~alu_y[WIDTH+1]};
        quot     = sign_q ? -div_lo : div_lo;
        // Only |MIN| / 1 with a positive sign can produce a magnitude that does not fit.
        div_ovf  = ~sign_q & div_lo[WIDTH-1];
`ifdef MULTDIV_REMAINDER_EN
        rem_fix  = rsign_q ? -div_hi[WIDTH-1:0] : div_hi[WIDTH-1:0];
`endif
    end

    // NOTE: every signal written below gets its default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        sign_d   = sign_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
        rsign_d  = rsign_q;
        rem_d    = rem_q;
`endif

        unique case (state_q)
            MULT: begin
                hi_d  = {1'b0, mul_sum[WIDTH:1]};
                lo_d  = mul_lo;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d  = DONE;
                    result_d = prod[WIDTH-1:0];
                    exc_d    = mul_ovf;
                    rdy_d    = 1'b1;
                end
            end
            DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d  = DONE;
                    result_d = quot;
                    exc_d    = div_ovf;
                    rdy_d    = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                    rem_d    = rem_fix;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // A start pulse wins over whatever is in flight; ctrl_MULT beats ctrl_DIV.
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            hi_d     = '0;
            cnt_d    = '0;
            result_d = '0;
            exc_d    = 1'b0;
            rdy_d    = 1'b0;
            sign_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
`ifdef MULTDIV_REMAINDER_EN
            rem_d    = '0;
            rsign_d  = 1'b0;
`endif
            if (bus.ctrl_MULT) begin
                opnd_d  = a_mag;
                lo_d    = b_mag;
                state_d = MULT;
            end else begin
                opnd_d  = b_mag;
                lo_d    = a_mag;
`ifdef MULTDIV_REMAINDER_EN
                rsign_d = bus.data_operandA[WIDTH-1];
`endif
                if (bus.data_operandB == '0) begin
                    state_d = DONE;
                    exc_d   = 1'b1;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = DIV;
                end
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            rsign_q  <= 1'b0;
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef MULTDIV_REMAINDER_EN
            rsign_q  <= rsign_d;
            rem_q    <= rem_d;
`endif
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q == MULT) || (state_q == DIV);
`ifdef MULTDIV_REMAINDER_EN
    assign bus.data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: vector table, corner sequences, and random ops vs a signed-arithmetic model.
// Remainder checks are compiled in when MULTDIV_REMAINDER_EN is defined.
module tb_multdiv_seq;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    multdiv_if #(.WIDTH(WIDTH)) bus ();
    multdiv_seq #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        bit          is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_e;
        logic [31:0] exp_rem;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the operand values.
    function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output logic [31:0] rm);
        int     sa, sb;
        longint p;
        sa = a;
        sb = b;
        rm = '0;
        if (is_mult) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'h0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r  = sa / sb;
            rm = sa % sb;
            e  = 1'b0;
        end
    endfunction

    // Called at a negedge; pulses the start and waits (bounded) for data_resultRDY.
    task automatic run_op(input bit do_mult, input bit do_div, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e, output logic [31:0] rm,
                          output int lat, output int busy_cyc);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = do_mult;
        bus.ctrl_DIV      = do_div;
        lat      = 0;
        busy_cyc = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            bus.ctrl_MULT = 1'b0;
            bus.ctrl_DIV  = 1'b0;
            if (bus.busy) busy_cyc++;
        end while (!bus.data_resultRDY && lat < 100);
        r = bus.data_result;
        e = bus.data_exception;
`ifdef MULTDIV_REMAINDER_EN
        rm = bus.data_remainder;
`else
        rm = '0;
`endif
    endtask

    task automatic exec_and_check(input string name, input bit do_mult, input bit do_div,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp_r, input logic exp_e,
                                  input logic [31:0] exp_rem, input int exp_lat);
        logic [31:0] r, rm;
        logic        e;
        int          lat, busy_cyc;
        run_op(do_mult, do_div, a, b, r, e, rm, lat, busy_cyc);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, busy_cyc, exp_lat - 1);
        check({name, " result"}, r, exp_r);
        check({name, " exception"}, e, exp_e);
`ifdef MULTDIV_REMAINDER_EN
        check({name, " remainder"}, rm, exp_rem);
`endif
        @(posedge clock);
        @(negedge clock);
        check({name, " rdy drop"}, bus.data_resultRDY, 1'b0);
        check({name, " result hold"}, bus.data_result, exp_r);
        check({name, " exception hold"}, bus.data_exception, exp_e);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 32)) - 32'd16;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] er, erm;
        logic        ee;
        int          rdy_seen;

        vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'd100,       32'd7,         32'd14,        1'b0, 32'd2};
        vecs[6]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'd1};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'd0,         32'd5,         32'd0,         1'b0, 32'd0};

        reset             = 1'b1;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset result", bus.data_result, 32'h0);
        check("reset exception", bus.data_exception, 1'b0);
        check("reset rdy", bus.data_resultRDY, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            exec_and_check($sformatf("vec%0d", i), vecs[i].is_mult, !vecs[i].is_mult,
                           vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_e, vecs[i].exp_rem, LAT);
        end

        // Divide by zero finishes one cycle after the start, never raising busy.
        exec_and_check("div5by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 32'd0, 1);

        // MULT 3*4 aborted at N+10 by DIV 100/7.
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        bus.ctrl_MULT     = 1'b1;
        rdy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            @(negedge clock);
            bus.ctrl_MULT = 1'b0;
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("abort busy before div", bus.busy, 1'b1);
        exec_and_check("abort div", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 32'd2, LAT);
        check("abort no early rdy", rdy_seen, 0);

        // Both starts together: MULT wins.
        exec_and_check("both starts", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, 32'd0, LAT);

        // Reset at N+15 of a MULT, with a DIV-by-zero start in the reset cycle that must be ignored.
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        bus.ctrl_MULT     = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            @(negedge clock);
            bus.ctrl_MULT = 1'b0;
        end
        reset             = 1'b1;
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd0;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset        = 1'b0;
        bus.ctrl_DIV = 1'b0;
        check("midop reset busy", bus.busy, 1'b0);
        check("midop reset rdy", bus.data_resultRDY, 1'b0);
        check("midop reset result", bus.data_result, 32'h0);
        check("midop reset exception", bus.data_exception, 1'b0);
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.data_resultRDY || bus.busy) rdy_seen++;
        end
        check("midop reset stays quiet", rdy_seen, 0);
        exec_and_check("after reset 2x2", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 32'd0, LAT);

        for (int i = 0; i < 24; i++) begin
            bit          m;
            logic [31:0] a, b;
            m = 1'($urandom_range(0, 1));
            a = pick_operand();
            b = pick_operand();
            model(m, a, b, er, ee, erm);
            exec_and_check($sformatf("rand%0d %s %h %h", i, m ? "mul" : "div", a, b), m, !m, a, b,
                           er, ee, erm, (!m && b == 32'h0) ? 1 : LAT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
